// File: rtl/alu_sequencer.sv
// Control sequencer for a shift-add ALU datapath: collects opcode and two
// operands via ENTER presses, runs add/sub/pass in one cycle or multiply in WIDTH steps.
module alu_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic       clk,
  input  logic       CLR,
  input  logic       ENTER,
  input  logic [1:0] OPCODE,
  input  logic       B_LSB,
  output logic       RESET,
  output logic       LoadOU,
  output logic       LoadA,
  output logic       LoadB,
  output logic       LoadR,
  output logic       IUAU,
  output logic       ClrR,
  output logic       AddEn,
  output logic       ShiftA,
  output logic       ShiftB,
  output logic       BUSY,
  output logic       DONE,
  output logic [2:0] STATE
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] OP_MUL = 2'b10;

  typedef enum logic [2:0] {
    IDLE     = 3'b000,
    GET_OP   = 3'b001,
    GET_A    = 3'b010,
    GET_B    = 3'b011,
    EXEC     = 3'b100,
    MUL_STEP = 3'b101,
    SHOW     = 3'b110
  } state_t;

  state_t          state_q, state_d;
  logic            enter_q, enter_d;
  logic [1:0]      op_q, op_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            enter_pulse;

  assign enter_pulse = ENTER & ~enter_q;

  // enter_q resets high so a button held through reset is not seen as a press
  always_ff @(posedge clk or negedge CLR) begin
    if (!CLR) begin
      state_q <= IDLE;
      enter_q <= 1'b1;
      op_q    <= 2'b00;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      enter_q <= enter_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    enter_d = ENTER;
    op_d    = op_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:   state_d = GET_OP;
      GET_OP: if (enter_pulse) begin
        op_d    = OPCODE;
        state_d = GET_A;
      end
      GET_A:  if (enter_pulse) state_d = GET_B;
      GET_B:  if (enter_pulse) state_d = EXEC;
      EXEC: begin
        if (op_q == OP_MUL) begin
          cnt_d   = CW'(WIDTH - 1);
          state_d = MUL_STEP;
        end else begin
          state_d = SHOW;
        end
      end
      // Exit on the cycle the counter reads zero, so it never wraps
      MUL_STEP: begin
        if (cnt_q == '0) state_d = SHOW;
        else             cnt_d   = cnt_q - 1'b1;
      end
      SHOW:   if (enter_pulse) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    RESET  = 1'b0;
    LoadOU = 1'b0;
    LoadA  = 1'b0;
    LoadB  = 1'b0;
    LoadR  = 1'b0;
    IUAU   = 1'b0;
    ClrR   = 1'b0;
    AddEn  = 1'b0;
    ShiftA = 1'b0;
    ShiftB = 1'b0;
    BUSY   = 1'b0;
    DONE   = 1'b0;
    STATE  = state_q;
    case (state_q)
      IDLE:   RESET  = 1'b1;
      GET_OP: LoadOU = enter_pulse;
      GET_A:  LoadA  = enter_pulse;
      GET_B:  LoadB  = enter_pulse;
      EXEC: begin
        BUSY = 1'b1;
        if (op_q == OP_MUL) begin
          ClrR = 1'b1;
        end else begin
          LoadR = 1'b1;
          IUAU  = 1'b1;
        end
      end
      MUL_STEP: begin
        BUSY   = 1'b1;
        AddEn  = B_LSB;
        ShiftA = 1'b1;
        ShiftB = 1'b1;
      end
      SHOW: begin
        DONE = 1'b1;
        IUAU = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Random + directed bench for alu_sequencer, checked every cycle against a
// phase-level model, plus literal latency/sequence expectations.
module tb_alu_sequencer;

  localparam int WIDTH = 4;

  logic       clk, CLR, ENTER, B_LSB;
  logic [1:0] OPCODE;
  logic       RESET, LoadOU, LoadA, LoadB, LoadR, IUAU, ClrR, AddEn, ShiftA, ShiftB, BUSY, DONE;
  logic [2:0] STATE;

  int n_cmp = 0;
  int n_bad = 0;

  alu_sequencer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .CLR(CLR), .ENTER(ENTER), .OPCODE(OPCODE), .B_LSB(B_LSB),
    .RESET(RESET), .LoadOU(LoadOU), .LoadA(LoadA), .LoadB(LoadB), .LoadR(LoadR),
    .IUAU(IUAU), .ClrR(ClrR), .AddEn(AddEn), .ShiftA(ShiftA), .ShiftB(ShiftB),
    .BUSY(BUSY), .DONE(DONE), .STATE(STATE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: phase number equals the documented state code; a multiply lasts
  // WIDTH cycles, tracked as a count of cycles still to run.
  int         m_phase;
  int         m_left;
  logic [1:0] m_op;
  logic       m_prev;

  always @(posedge clk or negedge CLR) begin
    if (!CLR) begin
      m_phase = 0; m_left = 0; m_op = 2'b00; m_prev = 1'b1;
    end else begin
      bit p;
      p = ENTER && !m_prev;
      m_prev = ENTER;
      case (m_phase)
        0: m_phase = 1;
        1: if (p) begin m_op = OPCODE; m_phase = 2; end
        2: if (p) m_phase = 3;
        3: if (p) m_phase = 4;
        4: if (m_op == 2'b10) begin m_left = WIDTH; m_phase = 5; end
           else m_phase = 6;
        5: begin m_left = m_left - 1; if (m_left == 0) m_phase = 6; end
        6: if (p) m_phase = 0;
        default: m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    logic [14:0] exp_v, act_v;
    bit p, ex, mul;
    #2;
    p   = ENTER && !m_prev;
    ex  = (m_phase == 4);
    mul = (m_op == 2'b10);
    exp_v = {m_phase == 0, m_phase == 1 && p, m_phase == 2 && p, m_phase == 3 && p,
             ex && !mul, (ex && !mul) || m_phase == 6, ex && mul,
             m_phase == 5 && B_LSB, m_phase == 5, m_phase == 5,
             ex || m_phase == 5, m_phase == 6, 3'(m_phase)};
    act_v = {RESET, LoadOU, LoadA, LoadB, LoadR, IUAU, ClrR, AddEn, ShiftA, ShiftB,
             BUSY, DONE, STATE};
    n_cmp++;
    if (act_v !== exp_v) begin
      n_bad++;
      $display("FAIL cycle_outputs t=%0t got=%h want=%h", $time, act_v, exp_v);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic press(input int hold);
    @(negedge clk); ENTER = 1'b1;
    repeat (hold) @(negedge clk);
    ENTER = 1'b0;
    @(negedge clk);
  endtask

  // Press from SHOW back to IDLE then GET_OP, checking DONE drops on exit
  task automatic leave_show();
    @(negedge clk); ENTER = 1'b1; #3;
    chk("show_done_before_exit", int'(DONE), 1);
    @(negedge clk); #3;
    chk("exit_to_idle", int'(STATE), 0);
    chk("exit_reset", int'(RESET), 1);
    chk("exit_done_low", int'(DONE), 0);
    @(negedge clk); #3;
    chk("exit_get_op", int'(STATE), 1);
    ENTER = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int lat, nmul;
    logic [3:0] pat, seen;
    CLR = 1'b0; ENTER = 1'b0; OPCODE = 2'b00; B_LSB = 1'b0;
    repeat (3) @(negedge clk);
    chk("model_reset_phase", m_phase, 0);
    CLR = 1'b1; #2;
    chk("release_state", int'(STATE), 0);
    chk("release_reset", int'(RESET), 1);
    @(negedge clk); #2;
    chk("after_release_state", int'(STATE), 1);
    repeat (5) @(negedge clk); #2;
    chk("get_op_hold", int'(STATE), 1);
    chk("get_op_no_loads", int'({LoadOU, LoadA, LoadB}), 0);

    // add: DONE two cycles after LoadB
    OPCODE = 2'b00;
    press(5); press(5);
    @(negedge clk); ENTER = 1'b1; #3;
    chk("add_loadb", int'(LoadB), 1);
    lat = 0;
    while (!DONE && lat < 40) begin @(negedge clk); #3; lat++; end
    chk("add_latency", lat, 2);
    repeat (3) @(negedge clk);
    ENTER = 1'b0;
    repeat (4) @(negedge clk); #2;
    chk("add_show_waits", int'(STATE), 6);
    leave_show();

    // mul with multiplier bits 1,0,1,1
    OPCODE = 2'b10; pat = 4'b1011;
    press(5); press(5);
    @(negedge clk); ENTER = 1'b1; #3;
    chk("mul_loadb", int'(LoadB), 1);
    lat = 0; nmul = 0; seen = '0;
    while (!DONE && lat < 40) begin
      @(negedge clk);
      B_LSB = (nmul < 4) ? pat[3-nmul] : 1'b0;
      #3; lat++;
      if (STATE == 3'b101) begin seen = {seen[2:0], AddEn}; nmul++; end
    end
    chk("mul_latency", lat, WIDTH + 2);
    chk("mul_steps", nmul, WIDTH);
    chk("mul_adden_seq", int'(seen), 4'b1011);
    ENTER = 1'b0;
    @(negedge clk);
    leave_show();

    // opcode changes after acceptance; add path must still run
    OPCODE = 2'b00;
    press(5);
    OPCODE = 2'b10;
    press(5);
    @(negedge clk); ENTER = 1'b1;
    @(negedge clk); ENTER = 1'b0; #3;
    chk("latched_add_loadr", int'(LoadR), 1);
    chk("latched_add_clrr", int'(ClrR), 0);
    repeat (4) @(negedge clk); #2;
    chk("latched_add_show", int'(STATE), 6);
    leave_show();

    // press during MUL_STEP is discarded; SHOW still waits for a new press
    OPCODE = 2'b10;
    press(5); press(5);
    @(negedge clk); ENTER = 1'b1;
    @(negedge clk); ENTER = 1'b0;
    @(negedge clk); ENTER = 1'b1; #3;
    chk("mid_mul_state", int'(STATE), 5);
    @(negedge clk); ENTER = 1'b0;
    repeat (8) @(negedge clk); #2;
    chk("mul_press_ignored", int'(STATE), 6);
    leave_show();

    // CLR in the second multiply step with ENTER held through release
    press(5); press(5);
    @(negedge clk); ENTER = 1'b1;
    repeat (3) @(negedge clk);
    CLR = 1'b0; #2;
    chk("clr_state", int'(STATE), 0);
    chk("clr_busy", int'(BUSY), 0);
    @(negedge clk); CLR = 1'b1;
    repeat (4) @(negedge clk); #2;
    chk("held_no_loadou", int'(LoadOU), 0);
    chk("held_state", int'(STATE), 1);
    @(negedge clk); ENTER = 1'b0;
    @(negedge clk); ENTER = 1'b1; #2;
    chk("repress_loadou", int'(LoadOU), 1);
    @(negedge clk); ENTER = 1'b0;

    // randomized traffic, model checks every cycle
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 99) < 15) ENTER = ~ENTER;
      OPCODE = 2'($urandom_range(0, 3));
      B_LSB  = 1'($urandom_range(0, 1));
      CLR    = ($urandom_range(0, 199) != 0);
    end
    @(negedge clk); CLR = 1'b1;
    repeat (2) @(negedge clk);
    #4;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
